// File: rtl/vga_box_renderer.sv
// Bouncing-box pixel generator for a VGA controller.
// A square box moves STEP pixels per axis each frame, bounces off the visible
// area borders and changes colour on every bounce. Runs on the falling pixel-clock edge.
module vga_box_renderer #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_SIZE = 32,
  parameter int unsigned STEP     = 2
) (
  input  logic       clock25Mhz,
  input  logic       reset,
  input  logic [9:0] column,
  input  logic [9:0] row,
  input  logic       freeze,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_tick
);

  // 11-bit arithmetic so x + BOX_SIZE + STEP never wraps
  localparam int unsigned CW = 11;
  localparam int unsigned PW = 10;

  typedef enum logic {H_RIGHT = 1'b0, H_LEFT = 1'b1} hdir_e;
  typedef enum logic {V_DOWN  = 1'b0, V_UP   = 1'b1} vdir_e;

  logic [PW-1:0] row_prev_q, row_prev_d;
  logic          frame_tick_q, frame_tick_d;
  logic [PW-1:0] x_q, x_d, y_q, y_d;
  hdir_e         hdir_q, hdir_d;
  vdir_e         vdir_q, vdir_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [7:0]    red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic          hbounce, vbounce;

  logic [CW-1:0] col_w, row_w, x_w, y_w;
  logic          inside_c, edge_c, visible_c;

  assign col_w = CW'(column);
  assign row_w = CW'(row);
  assign x_w   = CW'(x_q);
  assign y_w   = CW'(y_q);

  // Pixel classification against the current box position
  assign inside_c  = (col_w >= x_w) && (col_w < x_w + CW'(BOX_SIZE)) &&
                     (row_w >= y_w) && (row_w < y_w + CW'(BOX_SIZE));
  assign edge_c    = inside_c &&
                     ((col_w == x_w) || (col_w == x_w + CW'(BOX_SIZE - 1)) ||
                      (row_w == y_w) || (row_w == y_w + CW'(BOX_SIZE - 1)));
  assign visible_c = (col_w < CW'(H_ACTIVE)) && (row_w < CW'(V_ACTIVE));

  // Frame detection and once-per-frame box motion (pre-update values only)
  always_comb begin
    row_prev_d   = row;
    frame_tick_d = (row_prev_q != '0) && (row == '0);
    x_d          = x_q;
    y_d          = y_q;
    hdir_d       = hdir_q;
    vdir_d       = vdir_q;
    cidx_d       = cidx_q;
    hbounce      = 1'b0;
    vbounce      = 1'b0;
    if (frame_tick_q && !freeze) begin
      if (hdir_q == H_RIGHT) begin
        if (x_w + CW'(BOX_SIZE) + CW'(STEP) > CW'(H_ACTIVE)) begin
          x_d     = PW'(H_ACTIVE - BOX_SIZE);
          hdir_d  = H_LEFT;
          hbounce = 1'b1;
        end else begin
          x_d = x_q + PW'(STEP);
        end
      end else begin
        if (x_w < CW'(STEP)) begin
          x_d     = '0;
          hdir_d  = H_RIGHT;
          hbounce = 1'b1;
        end else begin
          x_d = x_q - PW'(STEP);
        end
      end
      if (vdir_q == V_DOWN) begin
        if (y_w + CW'(BOX_SIZE) + CW'(STEP) > CW'(V_ACTIVE)) begin
          y_d     = PW'(V_ACTIVE - BOX_SIZE);
          vdir_d  = V_UP;
          vbounce = 1'b1;
        end else begin
          y_d = y_q + PW'(STEP);
        end
      end else begin
        if (y_w < CW'(STEP)) begin
          y_d     = '0;
          vdir_d  = V_DOWN;
          vbounce = 1'b1;
        end else begin
          y_d = y_q - PW'(STEP);
        end
      end
      if (hbounce || vbounce) begin
        cidx_d = cidx_q + 2'd1;
      end
    end
  end

  // Pixel colour selection: blank, edge, box fill, background
  always_comb begin
    red_d   = 8'h00;
    green_d = 8'h00;
    blue_d  = 8'h00;
    if (!visible_c) begin
      red_d   = 8'h00;
    end else if (edge_c) begin
      red_d   = 8'hFF;
      green_d = 8'hFF;
      blue_d  = 8'hFF;
    end else if (inside_c) begin
      case (cidx_q)
        2'd0:    red_d = 8'hFF;
        2'd1:    green_d = 8'hFF;
        2'd2:    blue_d = 8'hFF;
        default: begin
          red_d   = 8'hFF;
          green_d = 8'hFF;
        end
      endcase
    end else begin
      red_d   = 8'h10;
      green_d = 8'h10;
      blue_d  = 8'h40;
    end
  end

  // State and output registers on the falling edge, async reset
  always_ff @(negedge clock25Mhz or posedge reset) begin
    if (reset) begin
      row_prev_q   <= '0;
      frame_tick_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      hdir_q       <= H_RIGHT;
      vdir_q       <= V_DOWN;
      cidx_q       <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
    end else begin
      row_prev_q   <= row_prev_d;
      frame_tick_q <= frame_tick_d;
      x_q          <= x_d;
      y_q          <= y_d;
      hdir_q       <= hdir_d;
      vdir_q       <= vdir_d;
      cidx_q       <= cidx_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign red        = red_q;
  assign green      = green_q;
  assign blue       = blue_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: pixel colours, frame detection,
// bounce/colour sequencing, freeze and asynchronous reset.
module tb_vga_box_renderer;

  logic       clk;
  logic       reset;
  logic [9:0] column;
  logic [9:0] row;
  logic       freeze;
  logic [7:0] red, green, blue;
  logic       frame_tick;
  logic [7:0] red_s, green_s, blue_s;
  logic       frame_tick_s;

  int n_cmp;
  int n_err;
  int ticks;

  vga_box_renderer dut (
    .clock25Mhz(clk), .reset(reset), .column(column), .row(row), .freeze(freeze),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  // Square screen instance for the simultaneous corner bounce
  vga_box_renderer #(.H_ACTIVE(480), .V_ACTIVE(480)) dut_sq (
    .clock25Mhz(clk), .reset(reset), .column(column), .row(row), .freeze(freeze),
    .red(red_s), .green(green_s), .blue(blue_s), .frame_tick(frame_tick_s)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel clock: DUT updates on negedge, bench samples/drives after posedge
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic set_pix(input int c, input int r);
    column = 10'(c);
    row    = 10'(r);
    cyc();
  endtask

  function automatic logic [31:0] rgb();
    return {8'h00, red, green, blue};
  endfunction

  // Row nonzero -> 0 produces one tick; the following cycle applies the move
  task automatic frame();
    row = 10'd1;
    cyc();
    row = 10'd0;
    cyc();
    if (frame_tick) ticks++;
    cyc();
    if (frame_tick) ticks++;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    ticks  = 0;
    reset  = 1'b1;
    column = '0;
    row    = '0;
    freeze = 1'b0;
    cyc();
    cyc();
    check("reset_rgb", rgb(), 32'h000000);
    check("reset_tick", 32'(frame_tick), 32'd0);
    check("reset_x", 32'(dut.x_q), 32'd0);
    check("reset_cidx", 32'(dut.cidx_q), 32'd0);
    reset = 1'b0;

    set_pix(0, 5);    check("edge_left", rgb(), 32'hFFFFFF);
    set_pix(10, 10);  check("fill_red", rgb(), 32'hFF0000);
    set_pix(31, 10);  check("edge_right", rgb(), 32'hFFFFFF);
    set_pix(10, 31);  check("edge_bottom", rgb(), 32'hFFFFFF);
    set_pix(32, 10);  check("bg_right", rgb(), 32'h101040);
    set_pix(700, 10); check("blank_col", rgb(), 32'h000000);
    set_pix(10, 479); check("bg_lastrow", rgb(), 32'h101040);
    set_pix(10, 480); check("blank_row", rgb(), 32'h000000);

    // Single frame start
    set_pix(10, 3);
    check("no_tick_pre", 32'(frame_tick), 32'd0);
    row = 10'd0;
    cyc();
    check("tick_high", 32'(frame_tick), 32'd1);
    cyc();
    check("tick_one_cycle", 32'(frame_tick), 32'd0);
    check("x_first", 32'(dut.x_q), 32'd2);
    check("y_first", 32'(dut.y_q), 32'd2);
    ticks = 0;
    repeat (4) begin
      cyc();
      if (frame_tick) ticks++;
    end
    check("no_retick_row0", 32'(ticks), 32'd0);

    set_pix(2, 2);   check("moved_edge", rgb(), 32'hFFFFFF);
    set_pix(1, 10);  check("moved_bg", rgb(), 32'h101040);
    set_pix(33, 10); check("moved_edge_r", rgb(), 32'hFFFFFF);

    // Freeze across three frames
    freeze = 1'b1;
    ticks  = 0;
    repeat (3) frame();
    check("frz_ticks", 32'(ticks), 32'd3);
    check("frz_x", 32'(dut.x_q), 32'd2);
    check("frz_y", 32'(dut.y_q), 32'd2);
    check("frz_cidx", 32'(dut.cidx_q), 32'd0);
    freeze = 1'b0;

    // 224 moving frames total: y reaches 448 without bouncing yet
    repeat (223) frame();
    check("f224_x", 32'(dut.x_q), 32'd448);
    check("f224_y", 32'(dut.y_q), 32'd448);
    check("f224_vdir", 32'(dut.vdir_q), 32'd0);
    check("f224_cidx", 32'(dut.cidx_q), 32'd0);
    check("sq224_x", 32'(dut_sq.x_q), 32'd448);
    check("sq224_cidx", 32'(dut_sq.cidx_q), 32'd0);

    frame();
    check("f225_y", 32'(dut.y_q), 32'd448);
    check("f225_vdir", 32'(dut.vdir_q), 32'd1);
    check("f225_x", 32'(dut.x_q), 32'd450);
    check("f225_cidx", 32'(dut.cidx_q), 32'd1);
    check("sq225_x", 32'(dut_sq.x_q), 32'd448);
    check("sq225_y", 32'(dut_sq.y_q), 32'd448);
    check("sq225_dirs", 32'({dut_sq.hdir_q, dut_sq.vdir_q}), 32'd3);
    check("sq225_cidx", 32'(dut_sq.cidx_q), 32'd1);

    repeat (79) frame();
    check("f304_x", 32'(dut.x_q), 32'd608);
    check("f304_hdir", 32'(dut.hdir_q), 32'd0);
    check("f304_y", 32'(dut.y_q), 32'd290);
    check("f304_cidx", 32'(dut.cidx_q), 32'd1);

    frame();
    check("f305_x", 32'(dut.x_q), 32'd608);
    check("f305_hdir", 32'(dut.hdir_q), 32'd1);
    check("f305_y", 32'(dut.y_q), 32'd288);
    check("f305_cidx", 32'(dut.cidx_q), 32'd2);

    set_pix(610, 300); check("fill_blue", rgb(), 32'h0000FF);

    // Mid-frame asynchronous reset
    #5;
    reset = 1'b1;
    #1;
    check("arst_rgb", rgb(), 32'h000000);
    check("arst_x", 32'(dut.x_q), 32'd0);
    check("arst_y", 32'(dut.y_q), 32'd0);
    row = 10'd0;
    cyc();
    reset = 1'b0;
    ticks = 0;
    repeat (3) begin
      cyc();
      if (frame_tick) ticks++;
    end
    check("post_rst_no_tick", 32'(ticks), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
